// File: rtl/midi_uart_rx_pkg.sv
// rtl/midi_uart_rx_pkg.sv - shared MIDI receiver constants and FSM state encoding
//
// Purpose: baud constant, default clocks-per-bit for a 12 MHz clock,
//          and the 3-bit receiver state encoding.
// Ports:   none (package).
package midi_uart_rx_pkg;

  localparam int MIDI_BAUD            = 31250;
  localparam int DEFAULT_CLKS_PER_BIT = 384;   // 12 MHz / 31250

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/midi_sync.sv
// rtl/midi_sync.sv - multi-stage flip-flop synchronizer, resets to 1 (idle line)
//
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset (all stages -> 1)
//   d    in   asynchronous input
//   q    out  synchronized output
module midi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI 8N1 serial receiver with one-deep valid/ready output
//
// Purpose: recover bytes from one MIDI input pin, hold each in a single
//          output register, flag framing errors and overruns.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   midi_rx    in   raw serial pin, asynchronous to clk
//   rx_data    out  received byte (valid while rx_valid)
//   rx_valid   out  rx_data holds an unconsumed byte
//   rx_ready   in   consumer accepts when rx_valid & rx_ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, byte dropped because holding reg full
//   busy       out  receiver not idle
module midi_uart_rx
  import midi_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  rx_state_t     state;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  midi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (midi_rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Plain accept; a byte completing this same cycle overrides it below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state      <= ST_START;
            sample_cnt <= HALF_LOAD;
            busy       <= 1'b1;
          end
        end

        ST_START: begin
          if (sample_cnt != '0) begin
            sample_cnt <= sample_cnt - 1'b1;
          end else if (rx_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= ST_DATA;
            sample_cnt <= FULL_LOAD;
            bit_cnt    <= '0;
          end
        end

        ST_DATA: begin
          if (sample_cnt != '0) begin
            sample_cnt <= sample_cnt - 1'b1;
          end else begin
            shift[bit_cnt] <= rx_s;
            sample_cnt     <= FULL_LOAD;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end

        ST_STOP: begin
          if (sample_cnt != '0) begin
            sample_cnt <= sample_cnt - 1'b1;
          end else if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!rx_valid || rx_ready) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= ST_BREAK;
          end
        end

        ST_BREAK: begin
          // Hold off until the line returns high so a long low is not a new start.
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
